pd_math_mc: RTL and testbench
=============================

Name: pd_math_mc

Overview:
Parametrised multi-channel PD math engine for the flight controller, replacing the single-channel PD math block.
- Computes saturated P and D terms for NUM_CH attitude channels (default roll/pitch/yaw) from one shared, time-multiplexed datapath.
- Gains are run-time programmable; derivative history depth is a parameter.
- Adds an overrun flag and a done strobe. Sits between the sensor/command path and the flight-control mixer.

Parameters:
NUM_CH, 3, number of channels processed per vld
DIN_W, 16, signed width of desired/actual
ERR_W, 10, saturated error width; also pterm width
DDIFF_W, 7, saturated derivative-difference width
GAIN_W, 5, unsigned gain width for p_gain and d_gain
Q_DEPTH, 12, number of samples back used for the derivative (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
vld  in  1  new sample strobe for all channels
desired  in  NUM_CH*DIN_W  signed setpoints; channel k at [k*DIN_W +: DIN_W]
actual  in  NUM_CH*DIN_W  signed measurements, same packing
p_gain  in  GAIN_W  unsigned P gain in eighths
d_gain  in  GAIN_W  unsigned D gain, integer
clr_q  in  1  clear derivative history and ovr
pterm  out  NUM_CH*ERR_W  signed P terms, packed as inputs
dterm  out  NUM_CH*(DDIFF_W+GAIN_W)  signed D terms, packed
rdy  out  1  one-cycle pulse: all outputs updated
busy  out  1  high in CALC and DONE
ovr  out  1  sticky: vld arrived while busy

Behaviour:
- Reset (async): state IDLE; pterm, dterm, rdy, busy, ovr, queue contents and write pointer all 0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: vld=1 and clr_q=0 latches desired, actual, p_gain and d_gain; sets ch_idx=0; moves to CALC.
  - CALC: one channel per clock, ch_idx 0..NUM_CH-1. After the last channel, moves to DONE.
  - DONE: rdy=1 for exactly one cycle; then IDLE.
- Latency: rdy is high in the cycle after edge E+NUM_CH+1, where E is the edge that sampled vld. A new vld is accepted in the cycle after DONE.
- Per-channel arithmetic (one channel per CALC cycle):
  - err = actual - desired, computed at DIN_W+1 bits, then saturated to ERR_W (-512..511 at default).
  - pterm = sat_ERR_W((err * p_gain) >>> 3). Floor (arithmetic) shift; gain is zero-extended before the multiply.
  - diff = sat_DDIFF_W(err - err_old), where err_old is this channel's err from Q_DEPTH accepted samples earlier, or 0 if that sample does not exist.
  - dterm = diff * d_gain at DDIFF_W+GAIN_W signed bits. This cannot overflow.
- Writeback: each channel's pterm/dterm registers update at the end of its CALC cycle. The channel's err is written into its history slot at the shared write pointer.
- Write pointer: advances modulo Q_DEPTH at the CALC→DONE transition.
- Overrun: vld while busy is ignored, sets ovr=1, and leaves in-flight results unaffected.
- clr_q: honoured in IDLE only; ignored in CALC/DONE.
  - Zeroes all history, the write pointer and ovr on the next edge.
  - Has priority over vld in the same cycle; that vld is dropped and does not set ovr.
  - Does not change pterm/dterm.
- Reset mid-CALC: everything returns to reset values, including partially updated outputs.
- Gain inputs may change freely while busy; the latched copies are used.

Decomposition:
- Package pd_pkg holds:
  - default width constants;
  - typedef state_t {IDLE, CALC, DONE};
  - function sat_signed(value, out_width), used for all saturations.
- Sub-module pd_err_queue: NUM_CH×Q_DEPTH×ERR_W circular history.
  - Read port addressed by (ch_idx, wptr); write port is the same address.
  - Inputs: clear and pointer advance.
  - Resets to zero.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0, busy=0, rdy never high.
2. Gains p=5, d=7. ch0 act=0x7FFF des=0; ch1 act=0 des=0x7FFF; ch2 act=5 des=0. Pulse vld -> rdy at edge E+4.
   - pterm = {319, -320, 3}
   - dterm = {441, -448, 35}
3. Q_DEPTH=4, ch0 err held at 5 for 5 samples, d=7 -> dterm0 = 35, 35, 35, 35, then 0 on the 5th sample.
4. vld held high through CALC/DONE -> ovr=1; only one computation and one rdy pulse per acceptance window; results identical to a single vld.
5. clr_q and vld together in IDLE -> no computation, ovr cleared. Next vld with err=5 -> dterm0 = 35, history restarted.
6. rst_n low during CALC at ch_idx=1 -> outputs immediately 0, busy=0. Next vld computes from empty history.

Source files
------------

// File: rtl/pd_pkg.sv
// pd_pkg: shared constants, FSM state type and saturation helper for the
// multi-channel PD math engine.
//   - Default width/depth constants used as parameter defaults.
//   - state_t: IDLE / CALC / DONE.
//   - sat_signed(): clamp a signed value to a narrower signed range.
package pd_pkg;

  localparam int unsigned NumChDef  = 3;
  localparam int unsigned DinWDef   = 16;
  localparam int unsigned ErrWDef   = 10;
  localparam int unsigned DdiffWDef = 7;
  localparam int unsigned GainWDef  = 5;
  localparam int unsigned QDepthDef = 12;

  // P gain is expressed in eighths.
  localparam int unsigned PShift = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp value into the signed range of out_width bits; the caller keeps the
  // low out_width bits of the result.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                    input int unsigned out_width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (out_width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) begin
      sat_signed = max_v;
    end else if (value < min_v) begin
      sat_signed = min_v;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/pd_err_queue.sv
// pd_err_queue: per-channel circular history of saturated errors.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero all history and the write pointer
//   advance    : step the shared write pointer modulo Q_DEPTH
//   we         : write wdata into slot (ch_idx, wptr)
//   ch_idx     : channel being processed
//   wdata      : current error for ch_idx
//   rdata      : error stored Q_DEPTH accepted samples ago in slot (ch_idx, wptr)
// Read and write share one address; the read returns the old contents, so
// each slot is consumed as the derivative reference and then overwritten.
module pd_err_queue
  import pd_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumChDef,
  parameter int unsigned ERR_W   = ErrWDef,
  parameter int unsigned Q_DEPTH = QDepthDef,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             we,
  input  logic [CH_W-1:0]  ch_idx,
  input  logic [ERR_W-1:0] wdata,
  output logic [ERR_W-1:0] rdata
);

  localparam int unsigned PtrW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  logic [ERR_W-1:0] mem_q [NUM_CH][Q_DEPTH];
  logic [PtrW-1:0]  wptr_q;

  assign rdata = mem_q[ch_idx][wptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int d = 0; d < Q_DEPTH; d++) begin
          mem_q[c][d] <= '0;
        end
      end
    end else if (clear) begin
      wptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int d = 0; d < Q_DEPTH; d++) begin
          mem_q[c][d] <= '0;
        end
      end
    end else begin
      if (we) begin
        mem_q[ch_idx][wptr_q] <= wdata;
      end
      if (advance) begin
        wptr_q <= (wptr_q == PtrW'(Q_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
      end
    end
  end

endmodule

// File: rtl/pd_math_mc.sv
// pd_math_mc: time-multiplexed PD math for NUM_CH channels.
//   clk, rst_n : clock, asynchronous active-low reset
//   vld        : new sample strobe (accepted in IDLE only)
//   desired    : packed signed setpoints, channel k at [k*DIN_W +: DIN_W]
//   actual     : packed signed measurements, same packing
//   p_gain     : unsigned P gain in eighths
//   d_gain     : unsigned integer D gain
//   clr_q      : in IDLE, clear derivative history and ovr
//   pterm      : packed signed P terms (ERR_W each)
//   dterm      : packed signed D terms (DDIFF_W+GAIN_W each)
//   rdy        : one-cycle pulse after all channels are written
//   busy       : high in CALC and DONE
//   ovr        : sticky, vld arrived while busy
module pd_math_mc
  import pd_pkg::*;
#(
  parameter int unsigned NUM_CH  = NumChDef,
  parameter int unsigned DIN_W   = DinWDef,
  parameter int unsigned ERR_W   = ErrWDef,
  parameter int unsigned DDIFF_W = DdiffWDef,
  parameter int unsigned GAIN_W  = GainWDef,
  parameter int unsigned Q_DEPTH = QDepthDef
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                vld,
  input  logic [NUM_CH*DIN_W-1:0]             desired,
  input  logic [NUM_CH*DIN_W-1:0]             actual,
  input  logic [GAIN_W-1:0]                   p_gain,
  input  logic [GAIN_W-1:0]                   d_gain,
  input  logic                                clr_q,
  output logic [NUM_CH*ERR_W-1:0]             pterm,
  output logic [NUM_CH*(DDIFF_W+GAIN_W)-1:0]  dterm,
  output logic                                rdy,
  output logic                                busy,
  output logic                                ovr
);

  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PW  = ERR_W + GAIN_W + 1;
  localparam int unsigned DW  = DDIFF_W + GAIN_W;

  state_t state_q, state_d;
  logic [ChW-1:0]            ch_q, ch_d;
  logic [NUM_CH*DIN_W-1:0]   des_q, act_q;
  logic [GAIN_W-1:0]         pg_q, dg_q;
  logic [NUM_CH*ERR_W-1:0]   pterm_q;
  logic [NUM_CH*DW-1:0]      dterm_q;
  logic                      rdy_q;
  logic                      ovr_q, ovr_d;
  logic                      latch, calc, q_adv, q_clr;

  // Datapath for the channel selected by ch_q
  logic signed [DIN_W-1:0]   act_s, des_s;
  logic signed [DIN_W:0]     err_full;
  logic signed [31:0]        err_sat, p_sat, d_sat;
  logic signed [ERR_W-1:0]   err_s, err_old_s, pterm_s;
  logic signed [PW-1:0]      prod, prod_sh;
  logic signed [ERR_W:0]     diff_full;
  logic signed [DDIFF_W-1:0] diff_s;
  logic signed [DW-1:0]      dterm_s;
  logic [ERR_W-1:0]          err_old;

  always_comb begin
    act_s     = act_q[ch_q*DIN_W +: DIN_W];
    des_s     = des_q[ch_q*DIN_W +: DIN_W];
    err_full  = (DIN_W+1)'(act_s) - (DIN_W+1)'(des_s);
    err_sat   = sat_signed(32'(err_full), ERR_W);
    err_s     = err_sat[ERR_W-1:0];
    // Gain is zero-extended so the multiply stays signed.
    prod      = PW'(err_s) * PW'($signed({1'b0, pg_q}));
    prod_sh   = prod >>> PShift;
    p_sat     = sat_signed(32'(prod_sh), ERR_W);
    pterm_s   = p_sat[ERR_W-1:0];
    err_old_s = err_old;
    diff_full = (ERR_W+1)'(err_s) - (ERR_W+1)'(err_old_s);
    d_sat     = sat_signed(32'(diff_full), DDIFF_W);
    diff_s    = d_sat[DDIFF_W-1:0];
    // Product of a DDIFF_W-bit diff and a GAIN_W-bit gain always fits in DW.
    dterm_s   = DW'(diff_s) * DW'($signed({1'b0, dg_q}));
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ovr_d   = ovr_q;
    latch   = 1'b0;
    calc    = 1'b0;
    q_adv   = 1'b0;
    q_clr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // clr_q wins over vld; the dropped vld is not an overrun.
        if (clr_q) begin
          q_clr = 1'b1;
          ovr_d = 1'b0;
        end else if (vld) begin
          latch   = 1'b1;
          ch_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        calc = 1'b1;
        if (vld) begin
          ovr_d = 1'b1;
        end
        if (ch_q == ChW'(NUM_CH - 1)) begin
          q_adv   = 1'b1;
          state_d = DONE;
        end else begin
          ch_d = ch_q + ChW'(1);
        end
      end
      DONE: begin
        if (vld) begin
          ovr_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ovr_q   <= 1'b0;
      rdy_q   <= 1'b0;
      des_q   <= '0;
      act_q   <= '0;
      pg_q    <= '0;
      dg_q    <= '0;
      pterm_q <= '0;
      dterm_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ovr_q   <= ovr_d;
      // Registered so the pulse lands in the cycle after leaving DONE.
      rdy_q   <= (state_q == DONE);
      if (latch) begin
        des_q <= desired;
        act_q <= actual;
        pg_q  <= p_gain;
        dg_q  <= d_gain;
      end
      if (calc) begin
        pterm_q[ch_q*ERR_W +: ERR_W] <= pterm_s;
        dterm_q[ch_q*DW +: DW]       <= dterm_s;
      end
    end
  end

  pd_err_queue #(
    .NUM_CH  (NUM_CH),
    .ERR_W   (ERR_W),
    .Q_DEPTH (Q_DEPTH),
    .CH_W    (ChW)
  ) u_err_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (q_clr),
    .advance (q_adv),
    .we      (calc),
    .ch_idx  (ch_q),
    .wdata   (err_s),
    .rdata   (err_old)
  );

  assign pterm = pterm_q;
  assign dterm = dterm_q;
  assign rdy   = rdy_q;
  assign busy  = (state_q != IDLE);
  assign ovr   = ovr_q;

endmodule

// File: tb/tb_pd_math_mc.sv
// Self-checking bench for pd_math_mc (3 channels, history depth 4).
module tb_pd_math_mc;

  localparam int NCH  = 3;
  localparam int DINW = 16;
  localparam int ERRW = 10;
  localparam int DDW  = 7;
  localparam int GW   = 5;
  localparam int QD   = 4;
  localparam int DW   = DDW + GW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 vld;
  logic [NCH*DINW-1:0]  desired;
  logic [NCH*DINW-1:0]  actual;
  logic [GW-1:0]        p_gain;
  logic [GW-1:0]        d_gain;
  logic                 clr_q;
  logic [NCH*ERRW-1:0]  pterm;
  logic [NCH*DW-1:0]    dterm;
  logic                 rdy;
  logic                 busy;
  logic                 ovr;

  int n_vec = 0;
  int n_err = 0;

  pd_math_mc #(
    .NUM_CH  (NCH),
    .DIN_W   (DINW),
    .ERR_W   (ERRW),
    .DDIFF_W (DDW),
    .GAIN_W  (GW),
    .Q_DEPTH (QD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld     (vld),
    .desired (desired),
    .actual  (actual),
    .p_gain  (p_gain),
    .d_gain  (d_gain),
    .clr_q   (clr_q),
    .pterm   (pterm),
    .dterm   (dterm),
    .rdy     (rdy),
    .busy    (busy),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a0, a1, a2;
    int d0, d1, d2;
    int pg, dg;
    int p0, p1, p2;
    int q0, q1, q2;
  } vec_t;

  vec_t vecs [5];

  function automatic int pt(int k);
    pt = int'($signed(pterm[k*ERRW +: ERRW]));
  endfunction

  function automatic int dt(int k);
    dt = int'($signed(dterm[k*DW +: DW]));
  endfunction

  task automatic chk(input string nm, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic set_in(input int a0, input int a1, input int a2,
                        input int d0, input int d1, input int d2,
                        input int pg, input int dg);
    actual  = {16'(a2), 16'(a1), 16'(a0)};
    desired = {16'(d2), 16'(d1), 16'(d0)};
    p_gain  = 5'(pg);
    d_gain  = 5'(dg);
  endtask

  // Returns the number of falling edges from the accepting edge to rdy, or -1.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic apply(input string nm, input int a0, input int a1, input int a2,
                       input int d0, input int d1, input int d2,
                       input int pg, input int dg);
    int lat;
    set_in(a0, a1, a2, d0, d1, d2, pg, dg);
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    wait_rdy(lat);
    chk({nm, "_latency"}, lat, 5);
  endtask

  task automatic clr();
    clr_q = 1'b1;
    @(posedge clk);
    #1 clr_q = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  cnt;
    logic seen;

    vecs[0] = '{32767, 0, 5,  0, 32767, 0,  5, 7,  319, -320, 3,  441, -448, 35};
    vecs[1] = '{100, 0, -3,  0, 100, -3,  8, 1,  100, -100, 0,  63, -64, 0};
    vecs[2] = '{-1, 7, -9,  0, 0, 0,  1, 31,  -1, 0, -2,  -31, 217, -279};
    vecs[3] = '{50, -20, 511,  0, 30, 0,  0, 0,  0, 0, 0,  0, 0, 0};
    vecs[4] = '{1000, -32768, 20,  -1000, 32767, 0,  31, 3,  511, -512, 77,  189, -192, 60};

    rst_n = 1'b0;
    vld   = 1'b0;
    clr_q = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;

    // Reset and idle
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rdy) seen = 1'b1;
    end
    chk("reset_pterm", longint'(pterm), 0);
    chk("reset_dterm", longint'(dterm), 0);
    chk("reset_rdy_seen", longint'(seen), 0);
    chk("reset_busy", longint'(busy), 0);
    chk("reset_ovr", longint'(ovr), 0);

    // Table vectors, each from empty history
    for (int i = 0; i < 5; i++) begin
      clr();
      apply($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].a2,
            vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].pg, vecs[i].dg);
      chk($sformatf("vec%0d_p0", i), pt(0), vecs[i].p0);
      chk($sformatf("vec%0d_p1", i), pt(1), vecs[i].p1);
      chk($sformatf("vec%0d_p2", i), pt(2), vecs[i].p2);
      chk($sformatf("vec%0d_d0", i), dt(0), vecs[i].q0);
      chk($sformatf("vec%0d_d1", i), dt(1), vecs[i].q1);
      chk($sformatf("vec%0d_d2", i), dt(2), vecs[i].q2);
    end

    // Derivative history wrap at depth 4
    clr();
    for (int s = 0; s < 5; s++) begin
      apply($sformatf("hist%0d", s), 5, 0, 0, 0, 0, 0, 0, 7);
      chk($sformatf("hist%0d_d0", s), dt(0), (s < 4) ? 35 : 0);
    end

    // vld held through CALC/DONE: one computation, ovr set
    clr();
    set_in(5, 0, 0, 0, 0, 0, 5, 7);
    vld = 1'b1;
    @(posedge clk);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rdy) cnt++;
      @(posedge clk);
    end
    #1 vld = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    chk("ovr_rdy_pulses", cnt, 1);
    chk("ovr_flag", longint'(ovr), 1);
    chk("ovr_busy", longint'(busy), 0);
    chk("ovr_p0", pt(0), 3);
    chk("ovr_d0", dt(0), 35);

    // Fill remaining history slots; ovr must stay sticky
    for (int s = 0; s < 3; s++) begin
      apply($sformatf("fill%0d", s), 5, 0, 0, 0, 0, 0, 5, 7);
      chk($sformatf("fill%0d_d0", s), dt(0), 35);
    end
    chk("ovr_sticky", longint'(ovr), 1);

    // clr_q together with vld in IDLE
    set_in(100, 0, 0, 0, 0, 0, 5, 7);
    vld   = 1'b1;
    clr_q = 1'b1;
    @(posedge clk);
    #1;
    vld   = 1'b0;
    clr_q = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy) cnt++;
    end
    chk("clr_rdy_pulses", cnt, 0);
    chk("clr_ovr", longint'(ovr), 0);
    chk("clr_busy", longint'(busy), 0);
    chk("clr_p0_kept", pt(0), 3);
    apply("after_clr", 5, 0, 0, 0, 0, 0, 5, 7);
    chk("after_clr_d0", dt(0), 35);

    // Fill history again, then reset mid-CALC
    for (int s = 0; s < 3; s++) begin
      apply($sformatf("refill%0d", s), 5, 0, 0, 0, 0, 0, 5, 7);
      chk($sformatf("refill%0d_d0", s), dt(0), 35);
    end
    set_in(5, 0, 0, 0, 0, 0, 5, 7);
    vld = 1'b1;
    @(posedge clk);
    #1 vld = 1'b0;
    @(posedge clk);
    #1;
    chk("midcalc_busy", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_pterm", longint'(pterm), 0);
    chk("midrst_dterm", longint'(dterm), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_rdy", longint'(rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 5, 0, 0, 0, 0, 0, 5, 7);
    chk("post_rst_p0", pt(0), 3);
    chk("post_rst_d0", dt(0), 35);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
